// File: rtl/gbe_tx_arb.sv
// Two-source MAC TX arbiter: whole-packet grants, MAX_LEN truncation, inter-frame gap.
// Define GBE_TX_ARB_STATS_EN to add app/cpu packet and truncation counters.
module gbe_tx_arb #(
   parameter int unsigned CPU_PRIORITY = 0,
   parameter int unsigned MAX_LEN      = 1518,
   parameter int unsigned IFG_CYCLES   = 12
) (
   input  logic        mac_clk,
   input  logic        mac_rst_n,
   input  logic        local_enable,
   input  logic        app_ready,
   input  logic [7:0]  app_data,
   input  logic        app_eof,
   output logic        app_rd,
   output logic        app_done,
   input  logic        cpu_ready,
   input  logic [7:0]  cpu_data,
   input  logic        cpu_eof,
   output logic        cpu_rd,
   output logic        cpu_done,
   output logic [7:0]  mac_tx_data,
   output logic        mac_tx_dvld,
   input  logic        mac_tx_ack,
   output logic        trunc_err,
   output logic        busy,
`ifdef GBE_TX_ARB_STATS_EN
   output logic [31:0] app_pkt_cnt,
   output logic [31:0] cpu_pkt_cnt,
   output logic [31:0] trunc_cnt,
`endif
   output logic        grant_cpu
);

   localparam logic [11:0] MAX_L = 12'(MAX_LEN);
   localparam logic [7:0]  IFG   = 8'(IFG_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_STREAM,
      S_DRAIN,
      S_GAP
   } state_t;

   state_t      state, state_nxt;
   logic [11:0] byte_cnt, byte_cnt_nxt, cnt_inc;
   logic [7:0]  gap_cnt, gap_cnt_nxt;
   logic        grant_nxt;
   logic        pop;
   logic        end_pkt;
   logic        trunc_nxt;
   logic        head_eof;
   logic        elig_app;

   assign elig_app = app_ready && local_enable;
   assign head_eof = grant_cpu ? cpu_eof : app_eof;
   assign cnt_inc  = byte_cnt + 12'd1;

   always_ff @(posedge mac_clk or negedge mac_rst_n) begin
      if (!mac_rst_n) begin
         state     <= S_IDLE;
         byte_cnt  <= '0;
         gap_cnt   <= '0;
         grant_cpu <= 1'b1;
         app_done  <= 1'b0;
         cpu_done  <= 1'b0;
         trunc_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         byte_cnt  <= byte_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         grant_cpu <= grant_nxt;
         app_done  <= end_pkt && !grant_cpu;
         cpu_done  <= end_pkt && grant_cpu;
         trunc_err <= trunc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      gap_cnt_nxt  = gap_cnt;
      grant_nxt    = grant_cpu;
      pop          = 1'b0;
      end_pkt      = 1'b0;
      trunc_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (cpu_ready || elig_app) begin
               // On a tie the source not granted last time wins unless CPU has priority.
               if (cpu_ready && elig_app)
                  grant_nxt = (CPU_PRIORITY != 0) ? 1'b1 : !grant_cpu;
               else
                  grant_nxt = cpu_ready;
               byte_cnt_nxt = '0;
               state_nxt    = S_LEAD;
            end
         end
         S_LEAD, S_STREAM: begin
            if (state == S_STREAM || mac_tx_ack) begin
               pop          = 1'b1;
               byte_cnt_nxt = cnt_inc;
               if (head_eof) begin
                  end_pkt     = 1'b1;
                  gap_cnt_nxt = '0;
                  state_nxt   = S_GAP;
               end else if (cnt_inc == MAX_L) begin
                  trunc_nxt = 1'b1;
                  state_nxt = S_DRAIN;
               end else begin
                  state_nxt = S_STREAM;
               end
            end
         end
         S_DRAIN: begin
            pop = 1'b1;
            if (head_eof) begin
               end_pkt     = 1'b1;
               gap_cnt_nxt = '0;
               state_nxt   = S_GAP;
            end
         end
         S_GAP: begin
            gap_cnt_nxt = gap_cnt + 8'd1;
            if (({1'b0, gap_cnt} + 9'd1) >= {1'b0, IFG})
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign mac_tx_dvld = (state == S_LEAD) || (state == S_STREAM);
   assign mac_tx_data = mac_tx_dvld ? (grant_cpu ? cpu_data : app_data) : 8'h00;
   assign app_rd      = pop && !grant_cpu;
   assign cpu_rd      = pop && grant_cpu;
   assign busy        = (state != S_IDLE);

`ifdef GBE_TX_ARB_STATS_EN
   always_ff @(posedge mac_clk or negedge mac_rst_n) begin
      if (!mac_rst_n) begin
         app_pkt_cnt <= '0;
         cpu_pkt_cnt <= '0;
         trunc_cnt   <= '0;
      end else begin
         if (app_done)  app_pkt_cnt <= app_pkt_cnt + 32'd1;
         if (cpu_done)  cpu_pkt_cnt <= cpu_pkt_cnt + 32'd1;
         if (trunc_err) trunc_cnt   <= trunc_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gbe_tx_arb.sv
// Scoreboard bench for gbe_tx_arb: packet-level source/MAC models and rule-based grant model.
`timescale 1ns/1ps
module tb_gbe_tx_arb;
   localparam int unsigned PRIO = 0;
   localparam int unsigned MAXL = 100;
   localparam int unsigned IFG  = 4;
   localparam int GAPL = (IFG == 0) ? 1 : int'(IFG);

   logic       mac_clk = 1'b0;
   logic       mac_rst_n = 1'b0;
   logic       local_enable = 1'b1;
   logic       app_ready = 1'b0, app_eof = 1'b0, cpu_ready = 1'b0, cpu_eof = 1'b0;
   logic [7:0] app_data = 8'h00, cpu_data = 8'h00;
   logic       app_rd, app_done, cpu_rd, cpu_done;
   logic [7:0] mac_tx_data;
   logic       mac_tx_dvld, trunc_err, busy, grant_cpu;
   logic       mac_tx_ack = 1'b0;
`ifdef GBE_TX_ARB_STATS_EN
   logic [31:0] app_pkt_cnt, cpu_pkt_cnt, trunc_cnt;
`endif

   gbe_tx_arb #(.CPU_PRIORITY(PRIO), .MAX_LEN(MAXL), .IFG_CYCLES(IFG)) dut (
      .mac_clk(mac_clk), .mac_rst_n(mac_rst_n), .local_enable(local_enable),
      .app_ready(app_ready), .app_data(app_data), .app_eof(app_eof),
      .app_rd(app_rd), .app_done(app_done),
      .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cpu_eof(cpu_eof),
      .cpu_rd(cpu_rd), .cpu_done(cpu_done),
      .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
      .trunc_err(trunc_err), .busy(busy),
`ifdef GBE_TX_ARB_STATS_EN
      .app_pkt_cnt(app_pkt_cnt), .cpu_pkt_cnt(cpu_pkt_cnt), .trunc_cnt(trunc_cnt),
`endif
      .grant_cpu(grant_cpu)
   );

   always #5 mac_clk = ~mac_clk;

   int checks = 0, failures = 0, cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Source contents as the DUT sees them, and the expected byte stream per source.
   logic [8:0] app_src[$], cpu_src[$], app_xb[$], cpu_xb[$];
   int app_pk = 0, cpu_pk = 0;

   task automatic push_pkt(input bit s, input int len);
      logic [8:0] b;
      for (int i = 0; i < len; i++) begin
         b = {(i == len - 1), 8'($urandom)};
         if (s) begin cpu_src.push_back(b); cpu_xb.push_back(b); end
         else   begin app_src.push_back(b); app_xb.push_back(b); end
      end
      if (s) cpu_pk++; else app_pk++;
   endtask

   function automatic logic [8:0] xb_head(input bit s);
      if (s) return (cpu_xb.size() > 0) ? cpu_xb[0] : 9'h100;
      return (app_xb.size() > 0) ? app_xb[0] : 9'h100;
   endfunction

   // Model state shared by monitor and MAC driver.
   bit in_pkt = 0, start_pending = 0, acked = 0, draining = 0, cur_src = 0, exp_src = 0;
   bit last_src = 1, done_src = 0, mon_off = 0;
   int pops = 0, idle_from = 0, done_cyc = -1, trunc_cyc = -1;
   int grant_log[$];
   int m_app = 0, m_cpu = 0, m_trunc = 0;
   int ack_dly = 2, lead_idx = 0;
   bit ack_rand = 0, stray_en = 0;

   // Source FIFOs and MAC ack driver.
   initial begin
      logic a_s, c_s;
      forever begin
         @(negedge mac_clk);
         a_s = app_rd;
         c_s = cpu_rd;
         @(posedge mac_clk);
         #1;
         if (!mac_rst_n) begin
            app_src.delete(); cpu_src.delete();
            app_pk = 0; cpu_pk = 0;
         end else begin
            if (a_s && app_src.size() > 0) begin
               if (app_src[0][8]) app_pk--;
               void'(app_src.pop_front());
            end
            if (c_s && cpu_src.size() > 0) begin
               if (cpu_src[0][8]) cpu_pk--;
               void'(cpu_src.pop_front());
            end
         end
         app_ready = (app_pk > 0);
         app_data  = (app_src.size() > 0) ? app_src[0][7:0] : 8'h00;
         app_eof   = (app_src.size() > 0) ? app_src[0][8] : 1'b0;
         cpu_ready = (cpu_pk > 0);
         cpu_data  = (cpu_src.size() > 0) ? cpu_src[0][7:0] : 8'h00;
         cpu_eof   = (cpu_src.size() > 0) ? cpu_src[0][8] : 1'b0;
         if (start_pending) begin
            if (ack_rand) ack_dly = $urandom_range(0, 4);
            lead_idx = 0;
            mac_tx_ack = (ack_dly == 0);
         end else if (in_pkt && !acked) begin
            lead_idx++;
            mac_tx_ack = (lead_idx == ack_dly);
         end else begin
            mac_tx_ack = stray_en && ($urandom_range(0, 7) == 0);
         end
      end
   end

   // Monitor: compares every cycle against the packet-level model.
   always @(negedge mac_clk) begin : mon
      logic [8:0] b;
      bit exp_rd, ea, ec;
      cyc++;
      if (!mon_off) begin
         chk("app_done", app_done, (done_cyc == cyc) && !done_src);
         chk("cpu_done", cpu_done, (done_cyc == cyc) && done_src);
         chk("trunc_err", trunc_err, trunc_cyc == cyc);
         if (start_pending) begin
            chk("grant_dvld", mac_tx_dvld, 1);
            chk("grant_src", grant_cpu, exp_src);
            start_pending = 0; in_pkt = 1; cur_src = exp_src; last_src = exp_src;
            acked = 0; draining = 0; pops = 0;
            grant_log.push_back(int'(exp_src));
         end
         if (in_pkt) begin
            b = xb_head(cur_src);
            chk("dvld", mac_tx_dvld, !draining);
            chk("data", mac_tx_data, draining ? 8'h00 : b[7:0]);
            exp_rd = draining || acked || mac_tx_ack;
            if (cur_src) begin
               chk("cpu_rd", cpu_rd, exp_rd);
               chk("app_rd_idle", app_rd, 0);
            end else begin
               chk("app_rd", app_rd, exp_rd);
               chk("cpu_rd_idle", cpu_rd, 0);
            end
            if (mac_tx_ack) acked = 1;
            if (exp_rd) begin
               if (cur_src) begin if (cpu_xb.size() > 0) void'(cpu_xb.pop_front()); end
               else begin if (app_xb.size() > 0) void'(app_xb.pop_front()); end
               pops++;
               if (b[8]) begin
                  in_pkt = 0; done_cyc = cyc + 1; done_src = cur_src;
                  idle_from = cyc + 1 + GAPL;
                  if (cur_src) m_cpu++; else m_app++;
               end else if (pops == int'(MAXL)) begin
                  draining = 1; trunc_cyc = cyc + 1; m_trunc++;
               end
            end
         end else begin
            chk("dvld_idle", mac_tx_dvld, 0);
            chk("data_idle", mac_tx_data, 0);
            chk("rd_idle", {app_rd, cpu_rd}, 0);
         end
         ea = app_ready && local_enable;
         ec = cpu_ready;
         if (!in_pkt && !start_pending && cyc >= idle_from && (ea || ec)) begin
            if (ea && ec) exp_src = (PRIO != 0) ? 1'b1 : !last_src;
            else          exp_src = ec;
            start_pending = 1;
         end
      end
   end

   task automatic wait_drain(input string name);
      int n = 0;
      while ((app_xb.size() > 0 || cpu_xb.size() > 0 || in_pkt || start_pending) && n < 20000) begin
         @(posedge mac_clk);
         n++;
      end
      chk({"drain_", name}, n < 20000, 1);
      repeat (GAPL + 3) @(posedge mac_clk);
      #2;
   endtask

   initial begin
      int n, a0, c0, t0, app_bytes;
      repeat (3) @(posedge mac_clk);
      #2;
      chk("rst_dvld", mac_tx_dvld, 0);
      chk("rst_rd", {app_rd, cpu_rd}, 0);
      chk("rst_done", {app_done, cpu_done}, 0);
      chk("rst_trunc", trunc_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_cpu", grant_cpu, 1);
      chk("rst_data", mac_tx_data, 0);
      mac_rst_n = 1'b1;
      @(posedge mac_clk); #2;

      // Both sources, four packets each.
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         push_pkt(0, $urandom_range(10, 40));
         push_pkt(1, $urandom_range(10, 40));
      end
      wait_drain("both");
      chk("grant_log_size", grant_log.size(), 8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         chk("grant_order", grant_log[i], (PRIO != 0) ? int'(i < 4) : (i % 2));

      // Single 64-byte app packet, ack three cycles into the lead.
      ack_dly = 3; a0 = m_app;
      push_pkt(0, 64);
      wait_drain("app64");
      chk("app64_done_cnt", m_app - a0, 1);

      // One-byte CPU packet.
      ack_dly = 1; c0 = m_cpu;
      push_pkt(1, 1);
      wait_drain("cpu1");
      chk("cpu1_done_cnt", m_cpu - c0, 1);

      // Truncation boundaries around MAX_LEN.
      ack_dly = 0;
      t0 = m_trunc; push_pkt(0, 150); wait_drain("len150");
      chk("trunc_150", m_trunc - t0, 1);
      t0 = m_trunc; push_pkt(0, MAXL); wait_drain("lenmax");
      chk("trunc_max", m_trunc - t0, 0);
      t0 = m_trunc; push_pkt(1, MAXL + 1); wait_drain("lenmax1");
      chk("trunc_max_plus1", m_trunc - t0, 1);
      t0 = m_trunc; push_pkt(0, MAXL - 1); wait_drain("lenmax_m1");
      chk("trunc_max_minus1", m_trunc - t0, 0);

      // local_enable low blocks app grants only.
      local_enable = 1'b0;
      push_pkt(0, 20); push_pkt(0, 30); push_pkt(1, 25); push_pkt(1, 15);
      n = 0;
      while ((cpu_xb.size() > 0 || in_pkt || start_pending) && n < 5000) begin
         @(posedge mac_clk); n++;
      end
      chk("le_cpu_served", n < 5000, 1);
      repeat (30) @(posedge mac_clk);
      #2;
      chk("le_app_blocked", app_xb.size(), 50);
      local_enable = 1'b1;
      wait_drain("le_release");

      // Dropping local_enable mid app packet leaves it intact.
      a0 = m_app; t0 = m_trunc;
      push_pkt(0, 80);
      n = 0;
      while (!(in_pkt && !cur_src && pops > 10) && n < 2000) begin
         @(posedge mac_clk); n++;
      end
      chk("le_mid_reach", n < 2000, 1);
      #2 local_enable = 1'b0;
      wait_drain("le_mid");
      chk("le_mid_done", m_app - a0, 1);
      chk("le_mid_no_trunc", m_trunc - t0, 0);
      local_enable = 1'b1;

      // Randomized traffic.
      ack_rand = 1; stray_en = 1;
      for (int i = 0; i < 30; i++) begin
         push_pkt($urandom_range(0, 1), $urandom_range(1, 130));
         local_enable = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(0, 150)) @(posedge mac_clk);
         #2;
      end
      local_enable = 1'b1;
      wait_drain("random");
`ifdef GBE_TX_ARB_STATS_EN
      chk("stat_app", app_pkt_cnt, m_app);
      chk("stat_cpu", cpu_pkt_cnt, m_cpu);
      chk("stat_trunc", trunc_cnt, m_trunc);
`endif

      // Asynchronous reset in the middle of a streaming packet.
      ack_rand = 0; stray_en = 0; ack_dly = 0;
      push_pkt(1, 60);
      n = 0;
      do begin
         @(negedge mac_clk); #1; n++;
      end while (!(in_pkt && acked && pops > 5 && !draining) && n < 2000);
      chk("rst_mid_reach", n < 2000, 1);
      chk("pre_rst_cpu_rd", cpu_rd, 1);
      #2;
      mon_off = 1;
      mac_rst_n = 1'b0;
      #1;
      chk("arst_dvld", mac_tx_dvld, 0);
      chk("arst_rd", {app_rd, cpu_rd}, 0);
      chk("arst_busy", busy, 0);
      chk("arst_grant_cpu", grant_cpu, 1);
      chk("arst_data", mac_tx_data, 0);
      repeat (3) @(posedge mac_clk);
      app_xb.delete(); cpu_xb.delete();
      #2 mac_rst_n = 1'b1;
      repeat (4) @(posedge mac_clk);
      #2;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_dvld", mac_tx_dvld, 0);
`ifdef GBE_TX_ARB_STATS_EN
      chk("post_rst_app_cnt", app_pkt_cnt, 0);
      chk("post_rst_cpu_cnt", cpu_pkt_cnt, 0);
      chk("post_rst_trunc_cnt", trunc_cnt, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

endmodule
